banked_dual_port_ctrl: RTL and testbench
========================================

# banked_dual_port_ctrl

Parametrised multi-bank memory controller that presents two independent request ports (A and B) on top of `BANK_NO` single-port RAM banks. The top address bits select the bank. Accesses to different banks proceed in parallel; a same-bank collision is resolved by a fair alternating arbiter that stalls the loser. Read data returns in order per port after a fixed `READ_LATENCY`, tagged with a valid strobe. It is the memory front-end for blocks that need two concurrent masters without the area of true dual-port arrays.

## Interface
- `ADDR_WIDTH`, 12, total word address width; the top `$clog2(BANK_NO)` bits are the bank select.
- `DATA_WIDTH`, 8, word width.
- `BANK_NO`, 4, number of banks; power of two, 2..16.
- `READ_LATENCY`, 3, cycles from request acceptance to read data; range 1..8.

Ports:
- `i_clk`  in  1  single clock, rising edge.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_ena`, `i_wea`  in  1 each  port A request valid / write (1) or read (0).
- `i_addra`  in  ADDR_WIDTH  port A address.
- `i_dina`  in  DATA_WIDTH  port A write data.
- `o_rdya`  out  1  port A request accepted this cycle when `i_ena & o_rdya`.
- `o_douta`  out  DATA_WIDTH  port A read data.
- `o_rvalida`  out  1  `o_douta` valid.
- `i_enb`, `i_web`, `i_addrb`, `i_dinb`, `o_rdyb`, `o_doutb`, `o_rvalidb`: identical for port B.
- `o_conflict_cnt`  out  16  saturating count of same-bank collisions.

## Operation
- Bank index = `addr[ADDR_WIDTH-1 -: BW]`, where `BW = $clog2(BANK_NO)`. Local word address = the remaining low `ADDR_WIDTH-BW` bits.
- Each bank is single-port: one read or write per cycle.
- A conflict exists when `i_ena & i_enb` and the two bank indices are equal.
- Without a conflict, both `o_rdya` and `o_rdyb` are 1. Each request goes to its bank in the same cycle.
- With a conflict, the arbiter grants the port indicated by the priority flop `prio` (0 = A, 1 = B). The other port's `o_rdy` is 0.
- After every conflict, `prio` flips to favour the loser. Sustained collisions therefore alternate A, B, A, …
- `prio` does not change on non-conflict cycles.
- `o_rdyx` is combinational from the current-cycle inputs and `prio`. The requester must hold address, data and write flag stable until accepted.
- A write commits to the bank array at the acceptance edge. A read accepted in a later cycle returns the new data.
- Read path:
  - The bank array has a 1-cycle registered read.
  - `READ_LATENCY-1` further pipeline stages carry the data, the bank id and the valid bit per port.
  - The output mux selects by the pipelined bank id.
- Writes produce no response. `o_rvalidx` stays 0 for them.
- Reset:
  - Clears `prio` to 0, all pipeline valids, `o_douta`/`o_doutb` to 0 and `o_conflict_cnt` to 0.
  - RAM contents are not reset.
  - Reset asserted mid-read discards in-flight reads: `o_rvalidx` is 0 from the cycle after the reset edge.
- Requests presented during reset are not accepted: `o_rdyx` is 0 while `i_rst_n` is 0.

## Timing
- Read accepted at edge N: `o_rvalidx` = 1 and data valid during cycle N+READ_LATENCY.
- Back-to-back reads on one port: one per cycle, in order, no bubbles except those caused by arbitration stalls.
- Conflict counter increments at the edge of every conflict cycle and saturates at 16'hFFFF.

## Configuration
- Macro `BANKED_DPC_CONFLICT_STATS_EN`.
- When defined: the conflict counter is implemented as specified.
- When undefined: no counter logic is built and `o_conflict_cnt` is tied to 0. Arbitration is unaffected.

## Structure
- Package `banked_dpc_pkg` holds:
  - function `bank_bits(BANK_NO)`;
  - typedef `port_e` {PORT_A, PORT_B} used for `prio`;
  - constant `CONFLICT_CNT_W = 16`.
- Sub-module `bank_sp_ram` is the single-port array: `DEPTH = 2**(ADDR_WIDTH-BW)`, 1-cycle registered read. It is instantiated `BANK_NO` times in a generate loop.
- The top module contains the decode, arbiter, read pipeline and output mux.

## Test plan
All scenarios use the defaults: `ADDR_WIDTH=12`, `BANK_NO=4`, `READ_LATENCY=3`.
- Port A writes 0x5A to 0x005 and port B writes 0xC3 to 0x405 in the same cycle → both `o_rdy` are 1. Later reads return 0x5A and 0xC3. Counter stays 0.
- Both ports read bank 2 (0x800, 0x801) for 4 consecutive cycles from reset → grants go A, B, A, B. `o_conflict_cnt` = 4. Each port gets 2 `o_rvalid` pulses, each 3 cycles after its accept.
- Port A writes 0x11 to 0xC00, then port A reads 0xC00 on the next cycle → `o_douta` = 0x11 with `o_rvalida` exactly 3 cycles after the read accept.
- Port A issues 3 back-to-back reads, then `i_rst_n` is pulled low for 1 cycle after the 2nd accept → no `o_rvalida` after the reset edge. `prio` = 0 and counter = 0 after reset.
- Both ports write bank 1 for 70000 conflicting cycles with the macro defined → counter saturates at 0xFFFF. With the macro undefined → counter reads 0 throughout.

Source files
------------

// File: rtl/banked_dpc_pkg.sv
// banked_dpc_pkg: shared types and helpers for banked_dual_port_ctrl.
//   bank_bits()     - number of address bits used to select a bank
//   port_e          - request port identifier, used for arbitration priority
//   CONFLICT_CNT_W  - width of the same-bank collision counter
package banked_dpc_pkg;

  localparam int CONFLICT_CNT_W = 16;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  function automatic int bank_bits(input int bank_no);
    return $clog2(bank_no);
  endfunction

endpackage

// File: rtl/bank_sp_ram.sv
// bank_sp_ram: single-port RAM bank, one read or write per cycle,
// registered read data (1-cycle latency). Contents are not reset.
// Ports:
//   i_clk   clock, rising edge
//   i_en    access enable
//   i_we    1 = write i_din to i_addr, 0 = read i_addr
//   i_addr  local word address (ADDR_W bits, DEPTH = 2**ADDR_W words)
//   i_din   write data
//   o_dout  read data, updated only on read accesses
module bank_sp_ram #(
  parameter int ADDR_W     = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_WIDTH-1:0] i_din,
  output logic [DATA_WIDTH-1:0] o_dout
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_din;
      end else begin
        o_dout <= r_mem[i_addr];
      end
    end
  end

endmodule

// File: rtl/banked_dual_port_ctrl.sv
// banked_dual_port_ctrl: two request ports (A, B) over BANK_NO single-port
// banks selected by the top address bits. Different-bank requests proceed in
// parallel; a same-bank collision is granted to the port held in the priority
// flop, which then flips to favour the loser. Reads return in order after
// READ_LATENCY cycles with a valid strobe; writes give no response.
// Ports:
//   i_clk, i_rst_n                clock, synchronous active-low reset
//   i_ena/i_wea/i_addra/i_dina    port A request (valid, write, addr, data)
//   o_rdya                        port A accepted when i_ena & o_rdya
//   o_douta/o_rvalida             port A read data and valid strobe
//   i_enb ... o_rvalidb           same for port B
//   o_conflict_cnt                saturating same-bank collision count
// Build option: define BANKED_DPC_CONFLICT_STATS_EN to build the collision
// counter; otherwise o_conflict_cnt is tied to zero.
module banked_dual_port_ctrl
  import banked_dpc_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 8,
  parameter int BANK_NO      = 4,
  parameter int READ_LATENCY = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_ena,
  input  logic                      i_wea,
  input  logic [ADDR_WIDTH-1:0]     i_addra,
  input  logic [DATA_WIDTH-1:0]     i_dina,
  output logic                      o_rdya,
  output logic [DATA_WIDTH-1:0]     o_douta,
  output logic                      o_rvalida,
  input  logic                      i_enb,
  input  logic                      i_web,
  input  logic [ADDR_WIDTH-1:0]     i_addrb,
  input  logic [DATA_WIDTH-1:0]     i_dinb,
  output logic                      o_rdyb,
  output logic [DATA_WIDTH-1:0]     o_doutb,
  output logic                      o_rvalidb,
  output logic [CONFLICT_CNT_W-1:0] o_conflict_cnt
);

  localparam int BW = bank_bits(BANK_NO);
  localparam int LW = ADDR_WIDTH - BW;

  logic [BW-1:0] w_bank [2];
  logic          w_conflict;
  logic          w_acc_a, w_acc_b;
  logic [1:0]    w_rd_acc;
  port_e         r_prio, w_prio_nxt;

  assign w_bank[0] = i_addra[ADDR_WIDTH-1 -: BW];
  assign w_bank[1] = i_addrb[ADDR_WIDTH-1 -: BW];

  // No request is accepted during reset, so no conflict is seen either.
  assign w_conflict = i_rst_n & i_ena & i_enb & (w_bank[0] == w_bank[1]);

  // Arbiter priority: state register / next state / outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_prio <= PORT_A;
    end else begin
      r_prio <= w_prio_nxt;
    end
  end

  always_comb begin
    w_prio_nxt = r_prio;
    if (w_conflict) begin
      w_prio_nxt = (r_prio == PORT_A) ? PORT_B : PORT_A;
    end
  end

  always_comb begin
    o_rdya = i_rst_n & (~w_conflict | (r_prio == PORT_A));
    o_rdyb = i_rst_n & (~w_conflict | (r_prio == PORT_B));
  end

  assign w_acc_a  = i_ena & o_rdya;
  assign w_acc_b  = i_enb & o_rdyb;
  assign w_rd_acc = {w_acc_b & ~i_web, w_acc_a & ~i_wea};

  // Bank array: an accepted request steers its bank; at most one port per
  // bank is ever accepted in a cycle.
  logic [DATA_WIDTH-1:0] w_ram_rd [BANK_NO];

  for (genvar g = 0; g < BANK_NO; g++) begin : g_bank
    logic                  w_sel_a, w_sel_b, w_en, w_we;
    logic [LW-1:0]         w_addr;
    logic [DATA_WIDTH-1:0] w_din;

    assign w_sel_a = w_acc_a & (w_bank[0] == BW'(g));
    assign w_sel_b = w_acc_b & (w_bank[1] == BW'(g));

    always_comb begin
      w_en   = w_sel_a | w_sel_b;
      w_we   = w_sel_a ? i_wea : i_web;
      w_addr = w_sel_a ? i_addra[LW-1:0] : i_addrb[LW-1:0];
      w_din  = w_sel_a ? i_dina : i_dinb;
    end

    bank_sp_ram #(
      .ADDR_W    (LW),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
      .i_clk (i_clk),
      .i_en  (w_en),
      .i_we  (w_we),
      .i_addr(w_addr),
      .i_din (w_din),
      .o_dout(w_ram_rd[g])
    );
  end

  // Read pipeline per port: r_vld[p][0] accompanies the RAM output cycle,
  // r_bk[p] remembers which bank holds that port's read data.
  logic [READ_LATENCY-1:0] r_vld [2];
  logic [BW-1:0]           r_bk  [2];
  logic [DATA_WIDTH-1:0]   w_mux [2];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int unsigned p = 0; p < 2; p++) begin
        r_vld[p] <= '0;
        r_bk[p]  <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < 2; p++) begin
        r_vld[p][0] <= w_rd_acc[p];
        for (int unsigned s = 1; s < READ_LATENCY; s++) begin
          r_vld[p][s] <= r_vld[p][s-1];
        end
        if (w_rd_acc[p]) begin
          r_bk[p] <= w_bank[p];
        end
      end
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      w_mux[p] = w_ram_rd[r_bk[p]];
    end
  end

  assign o_rvalida = r_vld[0][READ_LATENCY-1];
  assign o_rvalidb = r_vld[1][READ_LATENCY-1];

  if (READ_LATENCY == 1) begin : g_lat1
    // RAM output is not reset, so gate it to keep the output 0 until valid.
    assign o_douta = r_vld[0][0] ? w_mux[0] : '0;
    assign o_doutb = r_vld[1][0] ? w_mux[1] : '0;
  end else begin : g_latn
    // Each stage loads only when its data is valid, so the output holds the
    // most recent read result between responses.
    logic [DATA_WIDTH-1:0] r_dat [2][READ_LATENCY-1];

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        for (int unsigned p = 0; p < 2; p++) begin
          for (int unsigned s = 0; s < READ_LATENCY - 1; s++) begin
            r_dat[p][s] <= '0;
          end
        end
      end else begin
        for (int unsigned p = 0; p < 2; p++) begin
          if (r_vld[p][0]) begin
            r_dat[p][0] <= w_mux[p];
          end
          for (int unsigned s = 1; s < READ_LATENCY - 1; s++) begin
            if (r_vld[p][s]) begin
              r_dat[p][s] <= r_dat[p][s-1];
            end
          end
        end
      end
    end

    assign o_douta = r_dat[0][READ_LATENCY-2];
    assign o_doutb = r_dat[1][READ_LATENCY-2];
  end

`ifdef BANKED_DPC_CONFLICT_STATS_EN
  logic [CONFLICT_CNT_W-1:0] r_conflict_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_conflict_cnt <= '0;
    end else if (w_conflict && (r_conflict_cnt != '1)) begin
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  assign o_conflict_cnt = r_conflict_cnt;
`else
  assign o_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_banked_dual_port_ctrl.sv
// tb_banked_dual_port_ctrl: directed self-checking bench for
// banked_dual_port_ctrl with default parameters. Expected counter values
// follow BANKED_DPC_CONFLICT_STATS_EN (zero when the macro is undefined).
module tb_banked_dual_port_ctrl;

`ifdef BANKED_DPC_CONFLICT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena, wea, enb, web;
  logic [11:0] addra, addrb;
  logic [7:0]  dina, dinb;
  logic        rdya, rdyb, rvalida, rvalidb;
  logic [7:0]  douta, doutb;
  logic [15:0] cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  banked_dual_port_ctrl #(
    .ADDR_WIDTH  (12),
    .DATA_WIDTH  (8),
    .BANK_NO     (4),
    .READ_LATENCY(3)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_ena         (ena),
    .i_wea         (wea),
    .i_addra       (addra),
    .i_dina        (dina),
    .o_rdya        (rdya),
    .o_douta       (douta),
    .o_rvalida     (rvalida),
    .i_enb         (enb),
    .i_web         (web),
    .i_addrb       (addrb),
    .i_dinb        (dinb),
    .o_rdyb        (rdyb),
    .o_doutb       (doutb),
    .o_rvalidb     (rvalidb),
    .o_conflict_cnt(cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ec(input int n);
    return STATS ? 16'(n) : 16'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_a(input logic en, input logic we, input logic [11:0] ad, input logic [7:0] d);
    ena = en; wea = we; addra = ad; dina = d;
  endtask

  task automatic set_b(input logic en, input logic we, input logic [11:0] ad, input logic [7:0] d);
    enb = en; web = we; addrb = ad; dinb = d;
  endtask

  task automatic idle();
    set_a(1'b0, 1'b0, 12'h000, 8'h00);
    set_b(1'b0, 1'b0, 12'h000, 8'h00);
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int m;

    // Reset: requests are refused and outputs are cleared.
    rst_n = 1'b0;
    idle();
    set_a(1'b1, 1'b0, 12'h000, 8'h00);
    repeat (3) tick();
    settle();
    chk("rst_rdya", rdya, 0);
    chk("rst_rdyb", rdyb, 0);
    chk("rst_rvalida", rvalida, 0);
    chk("rst_douta", douta, 0);
    chk("rst_doutb", doutb, 0);
    chk("rst_cnt", cnt, ec(0));
    rst_n = 1'b1;
    idle();
    tick();

    // Parallel writes to banks 0 and 1, then parallel reads.
    set_a(1'b1, 1'b1, 12'h005, 8'h5A);
    set_b(1'b1, 1'b1, 12'h405, 8'hC3);
    settle();
    chk("t1_wr_rdya", rdya, 1);
    chk("t1_wr_rdyb", rdyb, 1);
    tick();
    set_a(1'b1, 1'b0, 12'h005, 8'h00);
    set_b(1'b1, 1'b0, 12'h405, 8'h00);
    settle();
    chk("t1_rd_rdya", rdya, 1);
    chk("t1_rd_rdyb", rdyb, 1);
    tick();
    idle();
    settle();
    chk("t1_lat1_rvalida", rvalida, 0);
    tick(); settle();
    chk("t1_lat2_rvalida", rvalida, 0);
    tick(); settle();
    chk("t1_rvalida", rvalida, 1);
    chk("t1_douta", douta, 8'h5A);
    chk("t1_rvalidb", rvalidb, 1);
    chk("t1_doutb", doutb, 8'hC3);
    tick(); settle();
    chk("t1_post_rvalida", rvalida, 0);
    chk("t1_cnt", cnt, ec(0));

    // Preload bank 2 from port A, then reset (RAM contents survive).
    set_a(1'b1, 1'b1, 12'h800, 8'hA0);
    tick();
    set_a(1'b1, 1'b1, 12'h801, 8'hB1);
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // Four cycles of same-bank reads straight from reset: grants A,B,A,B.
    set_a(1'b1, 1'b0, 12'h800, 8'h00);
    set_b(1'b1, 1'b0, 12'h801, 8'h00);
    for (int k = 0; k < 8; k++) begin
      if (k == 4) idle();
      settle();
      if (k < 4) begin
        chk($sformatf("t2_rdya_%0d", k), rdya, (k % 2) == 0);
        chk($sformatf("t2_rdyb_%0d", k), rdyb, (k % 2) == 1);
      end
      chk($sformatf("t2_rvalida_%0d", k), rvalida, (k == 3) || (k == 5));
      chk($sformatf("t2_rvalidb_%0d", k), rvalidb, (k == 4) || (k == 6));
      if ((k == 3) || (k == 5)) chk($sformatf("t2_douta_%0d", k), douta, 8'hA0);
      if ((k == 4) || (k == 6)) chk($sformatf("t2_doutb_%0d", k), doutb, 8'hB1);
      chk($sformatf("t2_cnt_%0d", k), cnt, ec((k < 4) ? k : 4));
      tick();
    end

    // Write then immediate read of the same word on port A.
    set_a(1'b1, 1'b1, 12'hC00, 8'h11);
    tick();
    set_a(1'b1, 1'b0, 12'hC00, 8'h00);
    settle();
    chk("t3_rdya", rdya, 1);
    tick();
    idle();
    settle();
    chk("t3_lat1_rvalida", rvalida, 0);
    tick(); settle();
    chk("t3_lat2_rvalida", rvalida, 0);
    tick(); settle();
    chk("t3_rvalida", rvalida, 1);
    chk("t3_douta", douta, 8'h11);

    // One more collision so priority ends up favouring B before the reset test.
    set_a(1'b1, 1'b1, 12'h400, 8'h77);
    set_b(1'b1, 1'b1, 12'h401, 8'h88);
    settle();
    chk("t3c_rdya", rdya, 1);
    chk("t3c_rdyb", rdyb, 0);
    tick();
    idle();
    settle();
    chk("t3c_cnt", cnt, ec(5));

    // Back-to-back reads on A with reset after the second accept.
    set_a(1'b1, 1'b0, 12'h005, 8'h00);
    settle();
    chk("t4_rdya_0", rdya, 1);
    tick();
    set_a(1'b1, 1'b0, 12'h800, 8'h00);
    tick();
    set_a(1'b1, 1'b0, 12'hC00, 8'h00);
    rst_n = 1'b0;
    settle();
    chk("t4_rst_rdya", rdya, 0);
    chk("t4_pre_rvalida", rvalida, 0);
    tick();
    rst_n = 1'b1;
    idle();
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("t4_rvalida_%0d", k), rvalida, 0);
      tick();
    end
    chk("t4_cnt", cnt, ec(0));
    set_a(1'b1, 1'b1, 12'h402, 8'h55);
    set_b(1'b1, 1'b1, 12'h403, 8'h66);
    settle();
    chk("t4_prio_rdya", rdya, 1);
    chk("t4_prio_rdyb", rdyb, 0);
    tick();
    idle();
    settle();
    chk("t4_cnt1", cnt, ec(1));

    // Sustained bank-1 collisions drive the counter into saturation.
    set_a(1'b1, 1'b1, 12'h410, 8'h01);
    set_b(1'b1, 1'b1, 12'h411, 8'h02);
    m = 1;
    for (int i = 0; i < 70000; i++) begin
      tick();
      if (m < 65535) m++;
      if ((i >= 65532) && (i < 65536)) chk($sformatf("t5_cnt_%0d", i), cnt, ec(m));
    end
    chk("t5_cnt_end", cnt, ec(65535));
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
